// File: rtl/piano_key_sequencer_pkg.sv
// Shared definitions for the piano key sequencer: state encodings, key codes,
// melody ROM entry layout and small decode helpers.
package piano_key_sequencer_pkg;

   // Melody ROM geometry
   localparam int unsigned KEY_W     = 4;
   localparam int unsigned FRAMES_W  = 6;
   localparam int unsigned ENTRY_W   = KEY_W + FRAMES_W;
   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned ROM_DEPTH = 16;

   // Key codes: 0..11 are notes C..B, 12/13 play as rests
   localparam int unsigned      NUM_KEYS = 12;
   localparam logic [KEY_W-1:0] KEY_REST = 4'hF;
   localparam logic [KEY_W-1:0] KEY_END  = 4'hE;

   // Named notes used by the default melody
   localparam logic [KEY_W-1:0] KEY_C = 4'd0;
   localparam logic [KEY_W-1:0] KEY_D = 4'd2;
   localparam logic [KEY_W-1:0] KEY_E = 4'd4;
   localparam logic [KEY_W-1:0] KEY_F = 4'd5;
   localparam logic [KEY_W-1:0] KEY_G = 4'd7;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      HOLD  = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } seqState_t;

   // One melody ROM entry: {key, frames}
   typedef struct packed {
      logic [KEY_W-1:0]    key;
      logic [FRAMES_W-1:0] frames;
   } romEntry_t;

   // Build a ROM entry from its fields
   function automatic romEntry_t makeEntry(input logic [KEY_W-1:0] key,
                                           input logic [FRAMES_W-1:0] frames);
      romEntry_t e;
      e.key    = key;
      e.frames = frames;
      return e;
   endfunction

   // True for keys that light a piano key (everything else is silent)
   function automatic logic isNote(input logic [KEY_W-1:0] key);
      return (key < KEY_W'(NUM_KEYS));
   endfunction

   // A zero duration still occupies one frame
   function automatic logic [FRAMES_W-1:0] effectiveFrames(input logic [FRAMES_W-1:0] frames);
      return (frames == '0) ? FRAMES_W'(1) : frames;
   endfunction

endpackage

// File: rtl/piano_melody_rom.sv
// 16 x 10 asynchronous-read melody ROM holding the default tune.
module piano_melody_rom
   import piano_key_sequencer_pkg::*;
(
   input  logic [ADDR_W-1:0] iAddr,
   output romEntry_t         oEntry_c
);

   // Default melody: C D E F G(long) rest G(long), then end markers
   always_comb begin
      oEntry_c = makeEntry(KEY_END, FRAMES_W'(0));
      case (iAddr)
         4'd0:    oEntry_c = makeEntry(KEY_C,    FRAMES_W'(4));
         4'd1:    oEntry_c = makeEntry(KEY_D,    FRAMES_W'(4));
         4'd2:    oEntry_c = makeEntry(KEY_E,    FRAMES_W'(4));
         4'd3:    oEntry_c = makeEntry(KEY_F,    FRAMES_W'(4));
         4'd4:    oEntry_c = makeEntry(KEY_G,    FRAMES_W'(8));
         4'd5:    oEntry_c = makeEntry(KEY_REST, FRAMES_W'(2));
         4'd6:    oEntry_c = makeEntry(KEY_G,    FRAMES_W'(8));
         default: oEntry_c = makeEntry(KEY_END,  FRAMES_W'(0));
      endcase
   end

endmodule

// File: rtl/piano_key_sequencer.sv
// Plays the melody ROM one entry at a time, timing notes and gaps in video
// frames derived from vsync, and drives the highlighted-key selection.
module piano_key_sequencer
   import piano_key_sequencer_pkg::*;
#(
   parameter int unsigned GAP_FRAMES = 2,
   parameter bit          LOOP       = 1'b1
)(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iVerticalSync,
   input  logic             iPlay,
   input  logic             iStep,
   output logic [KEY_W-1:0] oKeyIndex,
   output logic             oKeyValid,
   output logic             oNoteStart,
   output logic             oBusy
);

   localparam int unsigned GAP_W = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;

   seqState_t           state;
   logic [ADDR_W-1:0]   addr;
   logic [FRAMES_W-1:0] frameCnt;
   logic [GAP_W-1:0]    gapCnt;
   logic                stepMode;
   logic                vsyncQ1;
   logic                vsyncQ2;
   logic                frameTick;
   romEntry_t           romEntry;
   logic                entryIsNote;

   piano_melody_rom uRom (
      .iAddr    (addr),
      .oEntry_c (romEntry)
   );

   assign entryIsNote = isNote(romEntry.key);

   // Two-flop vsync capture; idles high so reset never fakes a tick
   always_ff @(posedge Clock) begin
      if (Reset) begin
         vsyncQ1 <= 1'b1;
         vsyncQ2 <= 1'b1;
      end else begin
         vsyncQ1 <= iVerticalSync;
         vsyncQ2 <= vsyncQ1;
      end
   end

   // One-cycle frame tick on the falling edge of vsync
   assign frameTick = vsyncQ2 & ~vsyncQ1;

   // Sequencer FSM with registered highlight, strobe and busy outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         addr       <= '0;
         frameCnt   <= '0;
         gapCnt     <= '0;
         stepMode   <= 1'b0;
         oKeyIndex  <= '0;
         oKeyValid  <= 1'b0;
         oNoteStart <= 1'b0;
         oBusy      <= 1'b0;
      end else begin
         oNoteStart <= 1'b0;
         unique case (state)
            IDLE: begin
               oBusy <= 1'b0;
               if (iPlay || iStep) begin
                  stepMode <= ~iPlay;
                  oBusy    <= 1'b1;
                  state    <= FETCH;
               end
            end

            FETCH: begin
               if (romEntry.key == KEY_END) begin
                  addr <= '0;
                  // Looping restarts from the top without leaving FETCH
                  if ((addr != '0) && LOOP && iPlay) begin
                     state <= FETCH;
                  end else begin
                     oBusy     <= 1'b0;
                     oKeyValid <= 1'b0;
                     state     <= DONE;
                  end
               end else begin
                  frameCnt   <= effectiveFrames(romEntry.frames);
                  oKeyIndex  <= romEntry.key;
                  oKeyValid  <= entryIsNote;
                  oNoteStart <= entryIsNote;
                  state      <= HOLD;
               end
            end

            HOLD: begin
               if (frameTick) begin
                  if (frameCnt <= FRAMES_W'(1)) begin
                     frameCnt  <= '0;
                     oKeyValid <= 1'b0;
                     addr      <= addr + ADDR_W'(1);
                     gapCnt    <= GAP_W'(GAP_FRAMES);
                     state     <= GAP;
                  end else begin
                     frameCnt <= frameCnt - FRAMES_W'(1);
                  end
               end
            end

            GAP: begin
               // Advance decision once the silent frames are used up
               if (gapCnt == '0) begin
                  if (stepMode || !iPlay) begin
                     oBusy <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= FETCH;
                  end
               end else if (frameTick) begin
                  gapCnt <= gapCnt - GAP_W'(1);
               end
            end

            DONE: begin
               oBusy     <= 1'b0;
               oKeyValid <= 1'b0;
               // Wait for both controls to be released so a held play does not retrigger
               if (!iPlay && !iStep) begin
                  state <= IDLE;
               end
            end

            default: begin
               oBusy     <= 1'b0;
               oKeyValid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
